matrix_stream_arbiter: RTL and testbench
========================================

// Module: matrix_stream_arbiter
// PURPOSE
//  Packet-granular 2:1 round-robin AXI-Stream arbiter sharing the matrix multiplier input_r stream
//  between two matrix sources (e.g. two generators). A grant is held from the first beat to TLAST,
//  so packets never interleave. Packets longer than MAX_BEATS are truncated: TLAST is forced on the
//  last allowed beat and the rest of that packet is drained. Sits between the sources and the
//  multiplier's input_r_* port.
// PARAMETERS
//  DATA_W     32    TDATA width
//  MAX_BEATS  1024  max beats forwarded per packet (>=2); beat counter width = $clog2(MAX_BEATS+1)
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       synchronous, active-low
//  s0_TDATA    in   DATA_W  source 0 data
//  s0_TVALID   in   1
//  s0_TLAST    in   1
//  s0_TREADY   out  1
//  s1_TDATA    in   DATA_W  source 1 data (same rules as s0)
//  s1_TVALID   in   1
//  s1_TLAST    in   1
//  s1_TREADY   out  1
//  m_TDATA     out  DATA_W  to multiplier input_r_TDATA
//  m_TVALID    out  1
//  m_TLAST     out  1
//  m_TREADY    in   1
//  grant       out  2       one-hot current owner; 2'b00 when IDLE
//  trunc_err   out  1       sticky; set on any truncation, cleared only by reset
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, grant=00, last_winner=1 (so s0 wins first),
//    beat_cnt=0, trunc_err=0. Outputs from reset: s*_TREADY=0, m_TVALID=0, m_TLAST=0, m_TDATA=0.
//  - Datapath combinational (zero latency): in PASS, m_* = granted s_*; granted s_TREADY=m_TREADY;
//    other s_TREADY=0. Beat = TVALID&TREADY on m side.
//  - FSM IDLE: if any s_TVALID, pick next per round-robin (prefer !last_winner; else the other);
//    register grant, last_winner -> PASS next cycle. No beat transfers in IDLE (1-cycle arb bubble).
//  - PASS: each beat beat_cnt++. Beat with s_TLAST and beat_cnt+1<=MAX_BEATS -> IDLE, cnt=0.
//    Beat number MAX_BEATS without s_TLAST: m_TLAST forced 1, trunc_err<=1 -> DRAIN.
//    Beat with TLAST exactly at MAX_BEATS: normal end, no error.
//  - DRAIN: m_TVALID=0; granted s_TREADY=1; beats discarded; on s_TLAST beat -> IDLE, cnt=0.
//  - Source TVALID drop mid-packet: grant held indefinitely (no timeout); other source blocked.
//  - Both valid in IDLE with last_winner=0 -> s1 wins; strict alternation under constant load.
//  - reset mid-packet: immediate return to IDLE; partial packet abandoned (sources reset together).
//  - m_TDATA/m_TLAST are 0 when m_TVALID=0.
// CONFIGURATION
//  ARB_PKT_COUNT_EN defined: adds outputs pkt_cnt0, pkt_cnt1 (32b each, wrap at 2^32) counting
//    completed packets forwarded per source (incl. truncated, counted at forced TLAST); reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package matrix_stream_pkg: state enum {IDLE,PASS,DRAIN}, GRANT_NONE/GRANT_S0/GRANT_S1 constants,
//    DATA_W default constant shared with generator/multiplier wrappers.
//  One sub-module: matrix_rr_pick (combinational round-robin pick from 2 valids + last_winner).
//  FSM, beat counter, mux in top.
// TESTING
//  1 Reset held 50 cycles with both sources valid -> all TREADY=0, m_TVALID=0, grant=00, trunc_err=0.
//  2 Only s0 sends 16-beat packet (data 1..16), m_TREADY=1 -> m sees 1..16, TLAST on 16, grant=01
//    throughout, IDLE one cycle after, trunc_err=0.
//  3 Both sources continuously send 4-beat packets (s0 0xA0.., s1 0xB0..) -> output order s0,s1,s0,s1,
//    no beat interleave, one bubble between packets.
//  4 MAX_BEATS=8, s1 sends 12-beat packet -> 8 beats out, TLAST on beat 8, beats 9..12 drained
//    (s1_TREADY=1, m_TVALID=0), trunc_err=1 sticky; exactly 8-beat packet -> no error.
//  5 m_TREADY toggled randomly 50% during 16-beat packet -> no lost/duplicated beat, s0_TREADY mirrors
//    m_TREADY; s0_TVALID gap of 100 cycles mid-packet -> grant held, s1 stalled.
//  6 reset asserted at beat 5 of 16 -> next cycle IDLE, grant=00; after release s0 wins first;
//    with ARB_PKT_COUNT_EN pkt counters read 0 then count correctly.

Source files
------------

// File: rtl/matrix_stream_pkg.sv
// Shared types and constants for the matrix stream arbiter and its generator/multiplier neighbours.
package matrix_stream_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

endpackage

// File: rtl/matrix_rr_pick.sv
// Combinational 2-way round-robin pick: the source that did not win last time gets priority.
module matrix_rr_pick (
    input  logic i_vld0,
    input  logic i_vld1,
    input  logic i_last_winner,
    output logic o_any,
    output logic o_pick
);

    always_comb begin
        o_any = i_vld0 | i_vld1;
        // o_pick: 1 selects s1; only meaningful when o_any is set
        if (i_last_winner) begin
            o_pick = ~i_vld0;
        end else begin
            o_pick = i_vld1;
        end
    end

endmodule

// File: rtl/matrix_stream_arbiter.sv
// Packet-granular 2:1 round-robin AXI-Stream arbiter with MAX_BEATS truncation and drain.
// Define ARB_PKT_COUNT_EN to add per-source completed-packet counters (pkt_cnt0/pkt_cnt1).
module matrix_stream_arbiter
    import matrix_stream_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_BEATS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s0_TDATA,
    input  logic              s0_TVALID,
    input  logic              s0_TLAST,
    output logic              s0_TREADY,
    input  logic [DATA_W-1:0] s1_TDATA,
    input  logic              s1_TVALID,
    input  logic              s1_TLAST,
    output logic              s1_TREADY,
    output logic [DATA_W-1:0] m_TDATA,
    output logic              m_TVALID,
    output logic              m_TLAST,
    input  logic              m_TREADY,
    output logic [1:0]        grant,
    output logic              trunc_err
`ifdef ARB_PKT_COUNT_EN
    ,
    output logic [31:0]       pkt_cnt0,
    output logic [31:0]       pkt_cnt1
`endif
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);

    arb_state_t        r_state;
    logic [1:0]        r_grant;
    logic              r_last_winner;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_trunc_err;

    logic              w_any;
    logic              w_pick;
    logic              w_sel;
    logic              w_src_vld;
    logic              w_src_last;
    logic [DATA_W-1:0] w_src_dat;
    logic              w_cap;
    logic              w_beat;

    matrix_rr_pick u_pick (
        .i_vld0        (s0_TVALID),
        .i_vld1        (s1_TVALID),
        .i_last_winner (r_last_winner),
        .o_any         (w_any),
        .o_pick        (w_pick)
    );

    assign w_sel      = r_grant[1];
    assign w_src_vld  = w_sel ? s1_TVALID : s0_TVALID;
    assign w_src_last = w_sel ? s1_TLAST  : s0_TLAST;
    assign w_src_dat  = w_sel ? s1_TDATA  : s0_TDATA;
    // Current beat is the last one allowed for this packet
    assign w_cap      = (r_beat_cnt == LAST_IDX);

    always_comb begin
        m_TVALID  = 1'b0;
        m_TDATA   = '0;
        m_TLAST   = 1'b0;
        s0_TREADY = 1'b0;
        s1_TREADY = 1'b0;
        case (r_state)
            PASS: begin
                m_TVALID  = w_src_vld;
                if (w_src_vld) begin
                    m_TDATA = w_src_dat;
                    m_TLAST = w_src_last | w_cap;
                end
                s0_TREADY = r_grant[0] & m_TREADY;
                s1_TREADY = r_grant[1] & m_TREADY;
            end
            DRAIN: begin
                s0_TREADY = r_grant[0];
                s1_TREADY = r_grant[1];
            end
            default: ;
        endcase
    end

    assign w_beat    = m_TVALID & m_TREADY;
    assign grant     = r_grant;
    assign trunc_err = r_trunc_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_grant       <= GRANT_NONE;
            r_last_winner <= 1'b1;
            r_beat_cnt    <= '0;
            r_trunc_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant       <= w_pick ? GRANT_S1 : GRANT_S0;
                        r_last_winner <= w_pick;
                        r_state       <= PASS;
                    end
                end
                PASS: begin
                    if (w_beat) begin
                        if (w_src_last) begin
                            r_state    <= IDLE;
                            r_grant    <= GRANT_NONE;
                            r_beat_cnt <= '0;
                        end else if (w_cap) begin
                            r_state     <= DRAIN;
                            r_trunc_err <= 1'b1;
                            r_beat_cnt  <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_src_vld && w_src_last) begin
                        r_state <= IDLE;
                        r_grant <= GRANT_NONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= GRANT_NONE;
                end
            endcase
        end
    end

`ifdef ARB_PKT_COUNT_EN
    logic [31:0] r_pkt_cnt0;
    logic [31:0] r_pkt_cnt1;

    // Truncated packets count at their forced TLAST, not at the drained source TLAST
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else if (w_beat && m_TLAST) begin
            if (r_grant[0]) begin
                r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
            end
            if (r_grant[1]) begin
                r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
            end
        end
    end

    assign pkt_cnt0 = r_pkt_cnt0;
    assign pkt_cnt1 = r_pkt_cnt1;
`endif

endmodule

// File: tb/tb_matrix_stream_arbiter.sv
// Scoreboard bench for matrix_stream_arbiter; MAX_BEATS=16 so a 16-beat packet is the exact boundary.
module tb_matrix_stream_arbiter;
    import matrix_stream_pkg::*;

    localparam int DW   = 32;
    localparam int MAXB = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] s0_TDATA = '0, s1_TDATA = '0;
    logic          s0_TVALID = 1'b0, s0_TLAST = 1'b0, s1_TVALID = 1'b0, s1_TLAST = 1'b0;
    logic          s0_TREADY, s1_TREADY;
    logic [DW-1:0] m_TDATA;
    logic          m_TVALID, m_TLAST;
    logic          m_TREADY = 1'b1;
    logic [1:0]    grant;
    logic          trunc_err;
`ifdef ARB_PKT_COUNT_EN
    logic [31:0]   pkt_cnt0, pkt_cnt1;
`endif

    matrix_stream_arbiter #(.DATA_W(DW), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .reset(reset),
        .s0_TDATA(s0_TDATA), .s0_TVALID(s0_TVALID), .s0_TLAST(s0_TLAST), .s0_TREADY(s0_TREADY),
        .s1_TDATA(s1_TDATA), .s1_TVALID(s1_TVALID), .s1_TLAST(s1_TLAST), .s1_TREADY(s1_TREADY),
        .m_TDATA(m_TDATA), .m_TVALID(m_TVALID), .m_TLAST(m_TLAST), .m_TREADY(m_TREADY),
        .grant(grant), .trunc_err(trunc_err)
`ifdef ARB_PKT_COUNT_EN
        , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
    );

    initial begin
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
        logic [1:0]  gnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_cyc = 0;
    logic rand_rdy = 1'b0, chk_bubble = 1'b0, bub_armed = 1'b0, chk_mirror = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input int src, input logic v, input logic [31:0] d, input logic l);
        if (src == 0) begin
            s0_TVALID = v; s0_TDATA = d; s0_TLAST = l;
        end else begin
            s1_TVALID = v; s1_TDATA = d; s1_TLAST = l;
        end
    endtask

    task automatic push_pkt(input int n, input logic [31:0] base, input logic [1:0] g, input logic last_on_final);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({base + 32'(i), (last_on_final && i == n - 1), g});
        end
    endtask

    // Sends n_send beats of a len-beat packet; optional valid gap before beat gap_at.
    task automatic send_pkt(input int src, input int n_send, input int len, input logic [31:0] base,
                            input int gap_at, input int gap_len);
        int   i = 0;
        int   stall = 0;
        logic rdy;
        while (i < n_send) begin
            if (i == gap_at && gap_len > 0) begin
                drive(src, 1'b0, 32'h0, 1'b0);
                repeat (gap_len) @(negedge clk);
                check("grant held in gap", {30'h0, grant}, {30'h0, (src == 0) ? GRANT_S0 : GRANT_S1});
                check("other TREADY in gap", {31'h0, (src == 0) ? s1_TREADY : s0_TREADY}, 32'h0);
                gap_len = 0;
            end
            drive(src, 1'b1, base + 32'(i), (i == len - 1));
            #1;
            rdy = (src == 0) ? s0_TREADY : s1_TREADY;
            @(negedge clk);
            if (rdy) begin
                i++;
                stall = 0;
            end else begin
                stall++;
                if (stall > 3000) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL send timeout: src %0d stuck at beat %0d, required handshake", src, i);
                    break;
                end
            end
        end
        drive(src, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    endtask

    always @(negedge clk) begin
        m_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops expected beats whenever a handshake is pending on the m side
    always @(negedge clk) begin
        exp_t e;
        #3;
        cyc++;
        if (reset) begin
            if (m_TVALID && m_TREADY) begin
                if (chk_bubble && bub_armed) begin
                    check("one-cycle bubble", 32'(cyc - last_cyc), 32'd2);
                end
                bub_armed = m_TLAST;
                last_cyc  = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected beat: got data 0x%0h, required no beat", m_TDATA);
                end else begin
                    e = exp_q.pop_front();
                    check("m_TDATA", m_TDATA, e.dat);
                    check("m_TLAST", {31'h0, m_TLAST}, {31'h0, e.last});
                    check("grant on beat", {30'h0, grant}, {30'h0, e.gnt});
                end
            end
            if (!m_TVALID) begin
                check("idle m_TDATA/m_TLAST zero", m_TDATA | {31'h0, m_TLAST}, 32'h0);
            end
            if (chk_mirror) begin
                check("s0_TREADY mirror", {31'h0, s0_TREADY}, {31'h0, (grant == GRANT_S0) & m_TREADY});
                check("s1_TREADY mirror", {31'h0, s1_TREADY}, {31'h0, (grant == GRANT_S1) & m_TREADY});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // 1: reset held with both sources valid
        drive(0, 1'b1, 32'h11, 1'b0);
        drive(1, 1'b1, 32'h22, 1'b0);
        repeat (50) @(negedge clk);
        check("reset s0_TREADY", {31'h0, s0_TREADY}, 32'h0);
        check("reset s1_TREADY", {31'h0, s1_TREADY}, 32'h0);
        check("reset m_TVALID", {31'h0, m_TVALID}, 32'h0);
        check("reset m_TDATA", m_TDATA, 32'h0);
        check("reset grant", {30'h0, grant}, 32'h0);
        check("reset trunc_err", {31'h0, trunc_err}, 32'h0);
        drive(0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // 2: s0 alone, 16 beats = exactly MAX_BEATS, no truncation
        push_pkt(16, 32'd1, GRANT_S0, 1'b1);
        send_pkt(0, 16, 16, 32'd1, -1, 0);
        check("grant IDLE after pkt", {30'h0, grant}, 32'h0);
        check("no trunc at exact max", {31'h0, trunc_err}, 32'h0);
        wait_empty(20);

        // 3: both sources back to back; s0 won last so s1 leads the alternation
        chk_bubble = 1'b1;
        bub_armed  = 1'b0;
        push_pkt(4, 32'hB0, GRANT_S1, 1'b1);
        push_pkt(4, 32'hA0, GRANT_S0, 1'b1);
        push_pkt(4, 32'hB4, GRANT_S1, 1'b1);
        push_pkt(4, 32'hA4, GRANT_S0, 1'b1);
        fork
            begin send_pkt(0, 4, 4, 32'hA0, -1, 0); send_pkt(0, 4, 4, 32'hA4, -1, 0); end
            begin send_pkt(1, 4, 4, 32'hB0, -1, 0); send_pkt(1, 4, 4, 32'hB4, -1, 0); end
        join
        wait_empty(20);
        chk_bubble = 1'b0;

        // 4: s1 sends 20 beats; 16 forwarded with forced TLAST, 4 drained
        push_pkt(16, 32'h40, GRANT_S1, 1'b1);
        fork
            send_pkt(1, 20, 20, 32'h40, -1, 0);
            begin
                k = 0;
                while (!trunc_err && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                #1;
                check("trunc_err set", {31'h0, trunc_err}, 32'h1);
                check("drain s1_TREADY", {31'h0, s1_TREADY}, 32'h1);
                check("drain m_TVALID", {31'h0, m_TVALID}, 32'h0);
            end
        join
        check("grant IDLE after drain", {30'h0, grant}, 32'h0);
        wait_empty(20);

        // 5: random m_TREADY, 100-cycle valid gap in s0 packet while s1 waits
        rand_rdy   = 1'b1;
        chk_mirror = 1'b1;
        push_pkt(16, 32'h50, GRANT_S0, 1'b1);
        push_pkt(2, 32'hC0, GRANT_S1, 1'b1);
        fork
            send_pkt(0, 16, 16, 32'h50, 8, 100);
            send_pkt(1, 2, 2, 32'hC0, -1, 0);
        join
        wait_empty(20);
        rand_rdy   = 1'b0;
        chk_mirror = 1'b0;
        check("trunc_err sticky", {31'h0, trunc_err}, 32'h1);
        repeat (2) @(negedge clk);

        // 6: reset after beat 5 of a 16-beat packet
        push_pkt(5, 32'h60, GRANT_S0, 1'b0);
        send_pkt(0, 5, 16, 32'h60, -1, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid-pkt reset grant", {30'h0, grant}, 32'h0);
        check("mid-pkt reset m_TVALID", {31'h0, m_TVALID}, 32'h0);
        check("mid-pkt reset trunc_err", {31'h0, trunc_err}, 32'h0);
`ifdef ARB_PKT_COUNT_EN
        check("pkt_cnt0 after reset", pkt_cnt0, 32'h0);
        check("pkt_cnt1 after reset", pkt_cnt1, 32'h0);
`endif
        wait_empty(5);
        reset = 1'b1;
        @(negedge clk);
        push_pkt(3, 32'hE0, GRANT_S0, 1'b1);
        push_pkt(3, 32'hD0, GRANT_S1, 1'b1);
        fork
            send_pkt(0, 3, 3, 32'hE0, -1, 0);
            send_pkt(1, 3, 3, 32'hD0, -1, 0);
        join
        wait_empty(20);
`ifdef ARB_PKT_COUNT_EN
        check("pkt_cnt0 counted", pkt_cnt0, 32'h1);
        check("pkt_cnt1 counted", pkt_cnt1, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
